// File: rtl/keypad_pkg.sv
// Shared types and width helpers for the keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    PRESSED,
    RELEASE_DB
  } kp_state_e;

  typedef enum logic [1:0] {
    EMPTY,
    SINGLE,
    MULTI
  } frame_class_e;

  function automatic int safe_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int code_width(input int rows, input int cols);
    return safe_clog2(rows * cols);
  endfunction

endpackage

// File: rtl/keypad_row_driver.sv
// One-cold row rotation with dwell counter; strobes the column sample on the
// last dwell cycle of each row and marks frame end on the last row's sample.
module keypad_row_driver
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic [ROWS-1:0]             keypad_row,
  output logic [safe_clog2(ROWS)-1:0] row_idx,
  output logic                        sample,
  output logic                        frame_end
);

  localparam int RW  = safe_clog2(ROWS);
  localparam int DVW = safe_clog2(SCAN_DIV);

  logic [DVW-1:0] dwell_q, dwell_d;
  logic [RW-1:0]  row_q, row_d;

  always_comb begin
    dwell_d    = dwell_q;
    row_d      = row_q;
    sample     = (dwell_q == DVW'(SCAN_DIV - 1));
    frame_end  = sample && (row_q == RW'(ROWS - 1));
    keypad_row = ~(ROWS'(1) << row_q);
    row_idx    = row_q;
    if (sample) begin
      dwell_d = '0;
      row_d   = frame_end ? '0 : row_q + RW'(1);
    end else begin
      dwell_d = dwell_q + DVW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_q <= '0;
      row_q   <= '0;
    end else begin
      dwell_q <= dwell_d;
      row_q   <= row_d;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: frame classification, debounce FSM, one-deep event
// output. Define KEYPAD_AUTOREPEAT_EN to add auto-repeat while a key is held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE     = 4,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [COLS-1:0]                     keypadCol,
  output logic [ROWS-1:0]                     keypadRow,
  output logic [code_width(ROWS, COLS)-1:0]   key_code,
  output logic                                key_valid,
  input  logic                                key_ack,
  output logic                                key_held,
  output logic                                overflow,
  output kp_state_e                           dbg_state
);

  localparam int CW  = code_width(ROWS, COLS);
  localparam int RW  = safe_clog2(ROWS);
  localparam int DBW = safe_clog2(DEBOUNCE + 1);

  logic [RW-1:0] row_idx;
  logic          sample, frame_end;

  keypad_row_driver #(.ROWS(ROWS), .SCAN_DIV(SCAN_DIV)) u_row_driver (
    .clk        (clk),
    .rst        (rst),
    .keypad_row (keypadRow),
    .row_idx    (row_idx),
    .sample     (sample),
    .frame_end  (frame_end)
  );

  logic [1:0]    acc_cnt_q, acc_cnt_d, merged_cnt;
  logic [CW-1:0] acc_idx_q, acc_idx_d, merged_idx, row_code;
  int            row_hits;
  frame_class_e  frame_cls;

  // Closure count saturates at 2: anything beyond one key is ghosting.
  always_comb begin
    row_hits = 0;
    row_code = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!keypadCol[c]) begin
        row_hits = row_hits + 1;
        row_code = CW'(int'(row_idx) * COLS + c);
      end
    end
    merged_cnt = acc_cnt_q;
    merged_idx = acc_idx_q;
    if (sample) begin
      if (row_hits >= 2 || (row_hits == 1 && acc_cnt_q != 2'd0)) begin
        merged_cnt = 2'd2;
      end else if (row_hits == 1) begin
        merged_cnt = 2'd1;
        merged_idx = row_code;
      end
    end
    frame_cls = (merged_cnt == 2'd0) ? EMPTY : (merged_cnt == 2'd1) ? SINGLE : MULTI;
    acc_cnt_d = frame_end ? 2'd0 : merged_cnt;
    acc_idx_d = frame_end ? '0 : merged_idx;
  end

  kp_state_e      state_q, state_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic [CW-1:0]  cand_q, cand_d;
  logic           press_event;

  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    cand_d      = cand_q;
    press_event = 1'b0;
    if (frame_end) begin
      unique case (state_q)
        IDLE: begin
          if (frame_cls == SINGLE) begin
            cand_d = merged_idx;
            if (DEBOUNCE == 1) begin
              state_d     = PRESSED;
              db_cnt_d    = '0;
              press_event = 1'b1;
            end else begin
              state_d  = PRESS_DB;
              db_cnt_d = DBW'(1);
            end
          end
        end
        PRESS_DB: begin
          if (frame_cls == SINGLE && merged_idx == cand_q) begin
            if (db_cnt_q == DBW'(DEBOUNCE - 1)) begin
              state_d     = PRESSED;
              db_cnt_d    = '0;
              press_event = 1'b1;
            end else begin
              db_cnt_d = db_cnt_q + DBW'(1);
            end
          end else begin
            state_d  = IDLE;
            db_cnt_d = '0;
          end
        end
        PRESSED: begin
          if (frame_cls == EMPTY) begin
            state_d  = (DEBOUNCE == 1) ? IDLE : RELEASE_DB;
            db_cnt_d = (DEBOUNCE == 1) ? '0 : DBW'(1);
          end
        end
        RELEASE_DB: begin
          if (frame_cls == EMPTY) begin
            if (db_cnt_q == DBW'(DEBOUNCE - 1)) begin
              state_d  = IDLE;
              db_cnt_d = '0;
            end else begin
              db_cnt_d = db_cnt_q + DBW'(1);
            end
          end else begin
            state_d  = PRESSED;
            db_cnt_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  logic emit;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPW     = safe_clog2(REP_MAX + 1);

  logic [RPW-1:0] rep_cnt_q, rep_cnt_d;
  logic           rep_event;

  // Counts down frames spent in PRESSED; every entry restarts the delay.
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    rep_event = 1'b0;
    if (frame_end) begin
      if (state_d == PRESSED && state_q != PRESSED) begin
        rep_cnt_d = RPW'(REPEAT_DELAY);
      end else if (state_d == PRESSED && state_q == PRESSED) begin
        if (rep_cnt_q == RPW'(1)) begin
          rep_event = 1'b1;
          rep_cnt_d = RPW'(REPEAT_RATE);
        end else begin
          rep_cnt_d = rep_cnt_q - RPW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rep_cnt_q <= '0;
    else     rep_cnt_q <= rep_cnt_d;
  end

  assign emit = press_event | rep_event;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_RATE};
  assign emit = press_event;
`endif

  logic [CW-1:0] key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          overflow_q, overflow_d;

  // valid/ready: key_valid is valid, key_ack is ready; a transfer happens in
  // a cycle where both are high. A new event may replace an event being
  // transferred in the same cycle; otherwise it is dropped and flagged.
  always_comb begin
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    overflow_d  = overflow_q;
    if (emit) begin
      if (!key_valid_q || key_ack) begin
        key_code_d  = cand_d;
        key_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (key_ack) begin
      key_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt_q   <= 2'd0;
      acc_idx_q   <= '0;
      state_q     <= IDLE;
      db_cnt_q    <= '0;
      cand_q      <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      acc_cnt_q   <= acc_cnt_d;
      acc_idx_q   <= acc_idx_d;
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign overflow  = overflow_q;
  assign key_held  = (state_q == PRESSED) || (state_q == RELEASE_DB);
  assign dbg_state = state_q;

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter ROWS, default 4: number of keypad rows driven.
REQ-002 SHALL have parameter COLS, default 4: number of keypad columns sampled.
REQ-003 SHALL have parameter SCAN_DIV, default 1000: clk cycles each row is driven (dwell), minimum 2.
REQ-004 SHALL have parameter DEBOUNCE, default 4: consecutive matching frames needed to accept a press or a release, minimum 1.
REQ-005 SHALL have parameters REPEAT_DELAY, default 50, and REPEAT_RATE, default 10: auto-repeat frame counts, used only under REQ-031.
REQ-006 SHALL have the port clk, input, 1 bit: the single clock.
REQ-007 SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have the port keypadCol, input, COLS bits: column sense, active-low (0 = key closed on the driven row).
REQ-009 SHALL have the port keypadRow, output, ROWS bits: one-cold row drive.
REQ-010 SHALL have the port key_code, output, clog2(ROWS*COLS) bits: accepted key index, row*COLS+col.
REQ-011 SHALL have the port key_valid, output, 1 bit: key_code holds an unconsumed event.
REQ-012 SHALL have the port key_ack, input, 1 bit: consumer takes the event.
REQ-013 SHALL have the port key_held, output, 1 bit: debounced key currently down.
REQ-014 SHALL have the port overflow, output, 1 bit: sticky flag, event lost.

Function
REQ-015 SHALL drive exactly one keypadRow bit low, advancing from bit r to bit (r+1) mod ROWS after SCAN_DIV cycles.
REQ-016 SHALL sample keypadCol on the last dwell cycle of each row; a frame is ROWS*SCAN_DIV cycles, ending after the last row's sample.
REQ-017 SHALL classify each frame as EMPTY (no closures), SINGLE (exactly one closure, with its index), or MULTI (two or more closures, i.e. ghosting).
REQ-018 SHALL run a debounce FSM with the states IDLE, PRESS_DB, PRESSED and RELEASE_DB, updated only at frame end.
REQ-019 IDLE: on a SINGLE frame, latch the candidate index, set count=1, go to PRESS_DB; on EMPTY or MULTI, stay in IDLE.
REQ-020 PRESS_DB: a SINGLE frame with the same index increments the count; a different index, EMPTY or MULTI frame returns to IDLE; on count reaching DEBOUNCE, go to PRESSED and emit an event.
REQ-021 With DEBOUNCE=1, an event SHALL be emitted at the end of the first SINGLE frame.
REQ-022 PRESSED: key_held=1; an EMPTY frame goes to RELEASE_DB with count=1; any other frame stays in PRESSED.
REQ-023 RELEASE_DB: each EMPTY frame increments the count, and reaching DEBOUNCE goes to IDLE with key_held=0; any non-EMPTY frame returns to PRESSED with no new event.
REQ-024 An event SHALL load key_code and set key_valid the cycle after the frame end; key_code SHALL stay stable while key_valid=1.
REQ-025 key_ack with key_valid=1 SHALL clear key_valid the next cycle; key_ack with key_valid=0 SHALL be ignored.
REQ-026 An event with key_valid=1 and no key_ack in the same cycle SHALL drop the new event and set overflow.
REQ-027 An event coinciding with key_ack SHALL load the new code and keep key_valid=1, without setting overflow.
REQ-028 overflow SHALL clear only on rst.

Reset
REQ-029 On rst, all of the following SHALL hold the cycle after: keypadRow={ROWS-1{1},0}; dwell, frame and debounce counters at 0; FSM in IDLE; key_code=0; key_valid=0; key_held=0; overflow=0.
REQ-030 rst mid-frame or mid-debounce SHALL discard the partial frame, and scanning SHALL restart at row 0.

Configuration
REQ-031 With KEYPAD_AUTOREPEAT_EN defined, PRESSED SHALL emit a repeat event of the same code REPEAT_DELAY frames after acceptance, then every REPEAT_RATE frames, until leaving PRESSED; repeat events SHALL follow REQ-024 to REQ-027.
REQ-032 Without KEYPAD_AUTOREPEAT_EN, exactly one event SHALL be emitted per accepted press, and no repeat counter logic SHALL be present.

Structure
REQ-033 Package keypad_pkg SHALL hold the FSM state enum, the frame-class enum (EMPTY/SINGLE/MULTI) and a code-width function of ROWS and COLS.
REQ-034 Sub-module keypad_row_driver SHALL own the dwell counter, row rotation, sample strobe and frame-end strobe; keypad_scanner SHALL own classification, the FSM and the output handshake.

Verification (ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=3; frame = 16 cycles)
REQ-035 rst 2 cycles, no keys -> keypadRow 1110, 1101, 1011, 0111, 1110, stepping every 4 cycles; key_valid stays 0.
REQ-036 Key at row 1, col 2 closed for 3 frames -> key_valid=1 and key_code=6 one cycle after the 3rd frame end; key_ack -> key_valid=0 the next cycle.
REQ-037 Row 1 col 2 bounces (closed, open, closed, closed, closed frames) -> exactly one event, emitted after the 5th frame; 2 empty frames then a press frame -> key_held stays 1 with no new event.
REQ-038 Row 0 cols 0 and 1 both closed for 5 frames -> no event, overflow=0; a second press with no ack -> overflow=1; an event coinciding with key_ack -> new code loaded, overflow unchanged.
REQ-039 Under KEYPAD_AUTOREPEAT_EN with REPEAT_DELAY=4 and REPEAT_RATE=2, key held 10 frames after acceptance with ack every event -> events at acceptance and at +4, +6, +8 and +10 frames; without the macro -> one event only.
